// File: rtl/bus_assert_arbiter_16bit_if.sv
// AddrBus/XferBus arbitration bundle: requests and locks in, active-low asserts, owners and orphan pulses out.
// master drives requests (control decode side); slave is the arbiter.
interface bus_assert_arbiter_16bit_if;
    logic [5:0] addr_req;
    logic       addr_lock;
    logic [5:0] xfer_req;
    logic       xfer_lock;
    logic [5:0] addr_assert_n;
    logic [5:0] xfer_assert_n;
    logic [2:0] addr_owner;
    logic [2:0] xfer_owner;
    logic       addr_orphan;
    logic       xfer_orphan;

    modport master (
        output addr_req, addr_lock, xfer_req, xfer_lock,
        input  addr_assert_n, xfer_assert_n, addr_owner, xfer_owner, addr_orphan, xfer_orphan
    );

    modport slave (
        input  addr_req, addr_lock, xfer_req, xfer_lock,
        output addr_assert_n, xfer_assert_n, addr_owner, xfer_owner, addr_orphan, xfer_orphan
    );
endinterface

// File: rtl/bus_assert_arbiter_16bit.sv
// Two independent six-source bus arbiters (Addr, Xfer) with round-robin/fixed priority and bounded lock.
// Latency 1 cycle request->assert; no backpressure, stall freezes all state and masks orphan pulses.
module bus_assert_arbiter_16bit_lane #(
    parameter bit FIXED_PRI = 1'b0,
    parameter int MAX_HOLD  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic [5:0] req,
    input  logic       lock,
    output logic [5:0] assert_n,
    output logic [2:0] owner,
    output logic       orphan
);
    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

    localparam logic [2:0] NONE = 3'd7;

    state_t     state, state_nx;
    logic [2:0] owner_nx, rr_ptr, rr_nx, pick, win_all, win_oth;
    logic [3:0] hold_cnt, hold_nx, hold_inc;
    logic [5:0] own_mask;
    logic       own_req, orphan_nx, do_arb;

    function automatic logic [5:0] onehot(input logic [2:0] o);
        logic [5:0] m;
        m = 6'd0;
        for (int i = 0; i < 6; i++)
            if (o == 3'(i)) m[i] = 1'b1;
        return m;
    endfunction

    // Scan in reverse so the last hit is the first in priority order.
    function automatic logic [2:0] arb(input logic [5:0] r, input logic [2:0] ptr);
        logic [2:0] w;
        int         idx;
        w = NONE;
        for (int k = 5; k >= 0; k--) begin
            idx = FIXED_PRI ? k : int'(ptr) + k;
            if (idx > 5) idx = idx - 6;
            if (r[idx[2:0]]) w = idx[2:0];
        end
        return w;
    endfunction

    assign own_mask = onehot(owner);
    assign own_req  = |(req & own_mask);
    assign win_all  = arb(req, rr_ptr);
    assign win_oth  = arb(req & ~own_mask, rr_ptr);
    assign hold_inc = (hold_cnt == 4'hF) ? hold_cnt : hold_cnt + 4'd1;

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        rr_nx     = rr_ptr;
        hold_nx   = hold_cnt;
        orphan_nx = 1'b0;
        do_arb    = 1'b0;
        pick      = NONE;
        case (state)
            IDLE: begin
                if (|req) begin
                    do_arb = 1'b1;
                    pick   = win_all;
                end
            end
            GRANT: begin
                if (lock && own_req) begin
                    state_nx = LOCKED;
                    hold_nx  = hold_inc;
                end else begin
                    do_arb = 1'b1;
                    pick   = win_all;
                end
            end
            LOCKED: begin
                if (!own_req) begin
                    orphan_nx = 1'b1;
                    do_arb    = 1'b1;
                    pick      = win_all;
                end else if (!lock) begin
                    do_arb = 1'b1;
                    pick   = win_all;
                end else if (hold_cnt == 4'(MAX_HOLD)) begin
                    // Forced release: others first, owner keeps the bus if nobody else wants it.
                    do_arb = 1'b1;
                    pick   = (win_oth != NONE) ? win_oth : owner;
                end else begin
                    hold_nx = hold_inc;
                end
            end
            default: begin
                state_nx = IDLE;
                owner_nx = NONE;
                hold_nx  = 4'd0;
            end
        endcase

        if (do_arb) begin
            if (pick == NONE) begin
                state_nx = IDLE;
                owner_nx = NONE;
                hold_nx  = 4'd0;
            end else begin
                state_nx = GRANT;
                owner_nx = pick;
                hold_nx  = 4'd1;
                if (!FIXED_PRI) rr_nx = (pick == 3'd5) ? 3'd0 : pick + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= NONE;
            rr_ptr   <= 3'd0;
            hold_cnt <= 4'd0;
            orphan   <= 1'b0;
            assert_n <= 6'h3F;
        end else if (stall) begin
            orphan <= 1'b0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_nx;
            hold_cnt <= hold_nx;
            orphan   <= orphan_nx;
            assert_n <= ~onehot(owner_nx);
        end
    end
endmodule

module bus_assert_arbiter_16bit #(
    parameter bit FIXED_PRI = 1'b0,
    parameter int MAX_HOLD  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    bus_assert_arbiter_16bit_if.slave   bus
);
    bus_assert_arbiter_16bit_lane #(.FIXED_PRI(FIXED_PRI), .MAX_HOLD(MAX_HOLD)) u_addr (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .req      (bus.addr_req),
        .lock     (bus.addr_lock),
        .assert_n (bus.addr_assert_n),
        .owner    (bus.addr_owner),
        .orphan   (bus.addr_orphan)
    );

    bus_assert_arbiter_16bit_lane #(.FIXED_PRI(FIXED_PRI), .MAX_HOLD(MAX_HOLD)) u_xfer (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .req      (bus.xfer_req),
        .lock     (bus.xfer_lock),
        .assert_n (bus.xfer_assert_n),
        .owner    (bus.xfer_owner),
        .orphan   (bus.xfer_orphan)
    );
endmodule

// File: tb/tb_bus_assert_arbiter_16bit.sv
// Bench for bus_assert_arbiter_16bit: round-robin and fixed-priority instances driven with identical inputs,
// expectations queued by the stimulus and checked by an independent monitor.
module tb_bus_assert_arbiter_16bit;
    logic       clk = 1'b0;
    logic       rst, stall;
    logic [5:0] a_req, x_req;
    logic       a_lock, x_lock;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        string      nm;
        int         due;
        bit         fx;
        bit         xb;
        logic [2:0] own;
        logic       orph;
    } exp_t;

    exp_t sb[$];

    bus_assert_arbiter_16bit_if if_rr ();
    bus_assert_arbiter_16bit_if if_fx ();

    assign if_rr.addr_req  = a_req;
    assign if_rr.addr_lock = a_lock;
    assign if_rr.xfer_req  = x_req;
    assign if_rr.xfer_lock = x_lock;
    assign if_fx.addr_req  = a_req;
    assign if_fx.addr_lock = a_lock;
    assign if_fx.xfer_req  = x_req;
    assign if_fx.xfer_lock = x_lock;

    bus_assert_arbiter_16bit #(.FIXED_PRI(1'b0), .MAX_HOLD(4)) dut_rr (
        .clk(clk), .rst(rst), .stall(stall), .bus(if_rr.slave));
    bus_assert_arbiter_16bit #(.FIXED_PRI(1'b1), .MAX_HOLD(4)) dut_fx (
        .clk(clk), .rst(rst), .stall(stall), .bus(if_fx.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] exp_asn(input logic [2:0] o);
        logic [5:0] v;
        v = 6'h3F;
        if (o < 3'd6) v[o] = 1'b0;
        return v;
    endfunction

    task automatic push(input string nm, input bit fx, input bit xb, input logic [2:0] own, input logic orph);
        exp_t e;
        e.nm = nm; e.due = cyc + 1; e.fx = fx; e.xb = xb; e.own = own; e.orph = orph;
        sb.push_back(e);
    endtask

    task automatic both_addr(input string nm, input logic [2:0] own, input logic orph);
        push(nm, 1'b0, 1'b0, own, orph);
        push(nm, 1'b1, 1'b0, own, orph);
    endtask

    task automatic all_idle(input string nm);
        both_addr(nm, 3'd7, 1'b0);
        push(nm, 1'b0, 1'b1, 3'd7, 1'b0);
        push(nm, 1'b1, 1'b1, 3'd7, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every expectation whose registering edge has passed.
    always @(negedge clk) begin
        exp_t       e;
        logic [2:0] a_own;
        logic [5:0] a_asn;
        logic       a_orph;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.fx) begin
                a_own  = e.xb ? if_fx.xfer_owner    : if_fx.addr_owner;
                a_asn  = e.xb ? if_fx.xfer_assert_n : if_fx.addr_assert_n;
                a_orph = e.xb ? if_fx.xfer_orphan   : if_fx.addr_orphan;
            end else begin
                a_own  = e.xb ? if_rr.xfer_owner    : if_rr.addr_owner;
                a_asn  = e.xb ? if_rr.xfer_assert_n : if_rr.addr_assert_n;
                a_orph = e.xb ? if_rr.xfer_orphan   : if_rr.addr_orphan;
            end
            n_cmp = n_cmp + 3;
            if (a_own !== e.own) begin
                n_bad++;
                $display("FAIL %s fx=%0d xfer=%0d owner: got %0d want %0d", e.nm, e.fx, e.xb, a_own, e.own);
            end
            if (a_asn !== exp_asn(e.own)) begin
                n_bad++;
                $display("FAIL %s fx=%0d xfer=%0d assert_n: got %h want %h", e.nm, e.fx, e.xb, a_asn, exp_asn(e.own));
            end
            if (a_orph !== e.orph) begin
                n_bad++;
                $display("FAIL %s fx=%0d xfer=%0d orphan: got %0d want %0d", e.nm, e.fx, e.xb, a_orph, e.orph);
            end
        end
    end

    logic [2:0] rr_seq [7];
    logic [2:0] rr_x   [3];

    initial begin
        rr_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        rr_x   = '{3'd2, 3'd3, 3'd5};

        // T1 reset with all requests up
        rst = 1'b1; stall = 1'b0; a_req = 6'h3F; a_lock = 1'b0; x_req = 6'h00; x_lock = 1'b0;
        all_idle("t1_reset");
        tick();

        // T2 round-robin rotation vs fixed priority
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            push("t2_rr", 1'b0, 1'b0, rr_seq[i], 1'b0);
            push("t2_fx", 1'b1, 1'b0, 3'd0, 1'b0);
            tick();
        end
        a_req = 6'h00;
        both_addr("t2_idle", 3'd7, 1'b0);
        tick();

        // T3 fixed priority on Xfer, drop of the winning bit
        x_req = 6'b101100;
        for (int i = 0; i < 3; i++) begin
            push("t3_fx", 1'b1, 1'b1, 3'd2, 1'b0);
            push("t3_rr", 1'b0, 1'b1, rr_x[i], 1'b0);
            tick();
        end
        x_req = 6'b101000;
        push("t3_drop_fx", 1'b1, 1'b1, 3'd3, 1'b0);
        push("t3_drop_rr", 1'b0, 1'b1, 3'd3, 1'b0);
        tick();
        x_req = 6'h00;
        push("t3_idle", 1'b1, 1'b1, 3'd7, 1'b0);
        push("t3_idle", 1'b0, 1'b1, 3'd7, 1'b0);
        tick();

        // T4 hold limit: src1 locked with src4 waiting
        a_req = 6'b010010; a_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            both_addr("t4_hold", 3'd1, 1'b0);
            tick();
        end
        both_addr("t4_release", 3'd4, 1'b0);
        tick();
        a_req = 6'b000010;
        for (int i = 0; i < 6; i++) begin
            both_addr("t4_regrant", 3'd1, 1'b0);
            tick();
        end
        a_req = 6'h00; a_lock = 1'b0;
        both_addr("t4_orphan_idle", 3'd7, 1'b1);
        tick();
        both_addr("t4_orphan_clr", 3'd7, 1'b0);
        tick();

        // T5 SP locked, drops request while DI pending
        a_req = 6'b010100; a_lock = 1'b1;
        both_addr("t5_grant", 3'd2, 1'b0);
        tick();
        both_addr("t5_locked", 3'd2, 1'b0);
        tick();
        a_req = 6'b010000;
        both_addr("t5_orphan", 3'd4, 1'b1);
        tick();
        a_lock = 1'b0;
        both_addr("t5_after", 3'd4, 1'b0);
        tick();

        // T6 stall freezes lock and hold count; reset beats stall
        a_req = 6'b010001; a_lock = 1'b1;
        both_addr("t6_lock", 3'd4, 1'b0);
        tick();
        stall = 1'b1; a_req = 6'h00; a_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            both_addr("t6_stall", 3'd4, 1'b0);
            tick();
        end
        stall = 1'b0; a_req = 6'b010001; a_lock = 1'b1;
        both_addr("t6_hold3", 3'd4, 1'b0);
        tick();
        both_addr("t6_hold4", 3'd4, 1'b0);
        tick();
        both_addr("t6_forced", 3'd0, 1'b0);
        tick();
        a_req = 6'b000001;
        both_addr("t6_relock", 3'd0, 1'b0);
        tick();
        rst = 1'b1; stall = 1'b1;
        all_idle("t6_rst");
        tick();
        rst = 1'b0; stall = 1'b0; a_req = 6'h00; a_lock = 1'b0;
        both_addr("t6_idle", 3'd7, 1'b0);
        tick();

        // Pointer restarts at 0 after reset
        a_req = 6'b100001;
        both_addr("ptr_reset", 3'd0, 1'b0);
        tick();
        push("ptr_next_rr", 1'b0, 1'b0, 3'd5, 1'b0);
        push("ptr_next_fx", 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        a_req = 6'h00;
        both_addr("end_idle", 3'd7, 1'b0);
        tick();

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad = n_bad + sb.size();
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
